uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 131 +++++++++++++
 tb/tb_uart_tx_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter feeding bytes from four requesters to a UART transmitter
//
// Ports:
//   clock_125   : single clock for all logic
//   rst_125     : asynchronous active-high reset
//   uart_cr     : UART control word, bit 1 = TE (transmit enable)
//   req_valid   : per-requester byte valid
//   req_data    : per-requester byte, requester i on [8i+7:8i]
//   req_ready   : per-requester accept strobe (combinational, IDLE only)
//   pi_data     : byte handed to the transmitter
//   pi_flag     : one-cycle start strobe to the transmitter
//   txend       : transmitter frame-complete pulse
//   busy        : high whenever a frame is in flight
//   grant_id    : requester owning the current or last frame
//   timeout_err : one-cycle pulse when a frame is abandoned
//   frame_cnt   : count of completed frames (wraps)
module uart_tx_arb #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                 clock_125,
  input  logic                 rst_125,
  input  logic [11:0]          uart_cr,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           pi_data,
  output logic                 pi_flag,
  input  logic                 txend,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic                 timeout_err,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LAUNCH   = 2'd1,
    S_WAIT_END = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  ptr;
  logic [31:0] tmo_cnt;
  logic [1:0]  cand;
  logic [1:0]  win_idx;
  logic        win_found;
  logic        accept;
  logic        frame_done;
  logic        frame_tmo;

  // Only TE is consumed from the control word.
  logic        unused_cr;
  assign unused_cr = ^{uart_cr[11:2], uart_cr[0]};

  // Round-robin search starting at ptr; the 2-bit index wraps modulo 4 on its own.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + k[1:0];
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // rst_125 is folded in so req_ready stays low while reset is held,
  // even though the state register already reads IDLE.
  assign accept    = (state == S_IDLE) && uart_cr[1] && win_found && !rst_125;
  assign req_ready = accept ? (NUM_REQ'(1) << win_idx) : '0;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    frame_tmo  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_nx = S_WAIT_END;
      end
      S_WAIT_END: begin
        // txend has priority over a coincident timeout.
        if (txend) begin
          frame_done = 1'b1;
          state_nx   = S_IDLE;
        end else if (tmo_cnt == 32'(TIMEOUT_CYC - 1)) begin
          frame_tmo = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_125 or posedge rst_125) begin
    if (rst_125) begin
      state       <= S_IDLE;
      ptr         <= 2'd0;
      grant_id    <= 2'd0;
      pi_flag     <= 1'b0;
      pi_data     <= 8'h00;
      tmo_cnt     <= 32'd0;
      frame_cnt   <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      pi_flag     <= (state_nx == S_LAUNCH);
      timeout_err <= frame_tmo;
      if (accept) begin
        pi_data  <= req_data[{win_idx, 3'b000} +: 8];
        grant_id <= win_idx;
        ptr      <= win_idx + 2'd1;
      end
      if (state == S_LAUNCH) begin
        tmo_cnt <= 32'd0;
      end else if (state == S_WAIT_END) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
      if (frame_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - self-checking bench for uart_tx_arb with a round-robin reference model
module tb_uart_tx_arb;

  localparam int TMO = 100;

  logic        clk;
  logic        rst_125;
  logic [11:0] uart_cr;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  pi_data;
  logic        pi_flag;
  logic        txend;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  int m_frames = 0;

  uart_tx_arb #(.NUM_REQ(4), .TIMEOUT_CYC(TMO)) dut (
    .clock_125   (clk),
    .rst_125     (rst_125),
    .uart_cr     (uart_cr),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .pi_data     (pi_data),
    .pi_flag     (pi_flag),
    .txend       (txend),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First set requester scanning from ptr upward, modulo 4.
  function automatic int rr_pick(input int ptr, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full frame. end_at: WAIT_END cycle index (0 = first) in which txend
  // is raised, or negative for never. drop_te: clear TE after launch and
  // pulse txend during LAUNCH, both of which must be ignored.
  task automatic do_frame(input logic [3:0] v, input logic [31:0] d,
                          input int end_at, input bit drop_te);
    int w, n, exp_n;
    bit exp_to;
    w = rr_pick(m_ptr, v);
    uart_cr   = 12'h002;
    req_valid = v;
    req_data  = d;
    #1;
    chk("req_ready_grant", req_ready, 32'(1) << w);
    chk("busy_idle", busy, 0);
    step();
    req_valid = 4'b0000;
    chk("pi_flag_launch", pi_flag, 1);
    chk("pi_data", pi_data, d[8*w +: 8]);
    chk("grant_id", grant_id, w);
    chk("req_ready_launch", req_ready, 0);
    m_ptr = (w + 1) % 4;
    if (drop_te) begin
      uart_cr = 12'h000;
      txend   = 1'b1;
    end
    step();
    txend = 1'b0;
    chk("pi_flag_wait", pi_flag, 0);
    n = 0;
    while (busy && n < 3 * TMO) begin
      if (n == end_at) txend = 1'b1;
      step();
      txend = 1'b0;
      n++;
    end
    if (end_at >= 0 && end_at < TMO) begin
      exp_n  = end_at + 1;
      exp_to = 1'b0;
      m_frames = (m_frames + 1) % 65536;
    end else begin
      exp_n  = TMO;
      exp_to = 1'b1;
    end
    chk("frame_len", n, exp_n);
    chk("timeout_err", timeout_err, exp_to);
    chk("frame_cnt", frame_cnt, m_frames);
    step();
    chk("timeout_err_clear", timeout_err, 0);
    uart_cr = 12'h002;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_pi_flag"}, pi_flag, 0);
    chk({tag, "_pi_data"}, pi_data, 0);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
    chk({tag, "_frames"}, frame_cnt, 0);
  endtask

  initial begin
    int viol;
    logic [3:0]  rv;
    logic [31:0] rd;
    int r, ea;

    rst_125   = 1'b1;
    uart_cr   = 12'h002;
    req_valid = 4'hF;
    req_data  = 32'h0;
    txend     = 1'b0;
    #1;
    chk_reset_vals("rst_hold");
    repeat (3) step();
    chk_reset_vals("rst_clocked");
    req_valid = 4'h0;
    rst_125   = 1'b0;

    // Round-robin with all four requesting: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) do_frame(4'hF, 32'hA3A2A1A0, 2, 1'b0);

    // Single request, txend about ten cycles after launch.
    do_frame(4'b0001, 32'h00000055, 9, 1'b0);

    // TE gating.
    uart_cr   = 12'h000;
    req_valid = 4'b0010;
    viol = 0;
    repeat (50) begin
      step();
      if (req_ready !== 4'b0000 || pi_flag !== 1'b0 || busy !== 1'b0) viol++;
    end
    chk("te_gating", viol, 0);
    do_frame(4'b0010, 32'h00C30000, 3, 1'b0);

    // txend in IDLE is ignored.
    req_valid = 4'b0000;
    txend = 1'b1;
    step();
    txend = 1'b0;
    chk("txend_idle", frame_cnt, m_frames);
    chk("txend_idle_busy", busy, 0);

    // Timeout, then the next grant moves on.
    do_frame(4'hF, 32'h44332211, -1, 1'b0);
    do_frame(4'hF, 32'h88776655, 1, 1'b0);

    // txend coincident with the timeout cycle.
    do_frame(4'b1001, 32'h5A0000A5, TMO - 1, 1'b0);

    // TE dropped mid-frame and txend in LAUNCH do not disturb the frame.
    do_frame(4'b0100, 32'h00EE0000, 4, 1'b1);

    // Reset in WAIT_END.
    uart_cr   = 12'h002;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    repeat (6) step();
    rst_125 = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    step();
    rst_125  = 1'b0;
    m_ptr    = 0;
    m_frames = 0;
    do_frame(4'b1010, 32'h7700BB00, 0, 1'b0);

    // Randomized frames against the model.
    for (int i = 0; i < 120; i++) begin
      rv = 4'($urandom_range(1, 15));
      rd = $urandom;
      r  = $urandom_range(0, 19);
      ea = (r == 0) ? -1 : (r == 1) ? TMO - 1 : $urandom_range(0, 6);
      do_frame(rv, rd, ea, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
